// File: rtl/video_stream_out_buffer.sv
// Output stage of the image pipeline: buffers pixel beats with their sideband
// in a first-word-fall-through FIFO and re-issues them as an AXI4-Stream master.
module video_stream_out_buffer #(
  parameter int DATA_W    = 24,
  parameter int USER_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic [USER_W-1:0] in_tuser,
  input  logic              in_tvalid,
  input  logic              in_tlast,
  output logic              in_ready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [USER_W-1:0] m_tuser,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  input  logic              clr_status,
  output logic              overflow,
  output logic              err_sof,
  output logic [CNT_W-1:0]  last_line_len,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = DATA_W + USER_W + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q, count_d;
  logic [AW:0]        free_d;
  logic               in_ready_q, in_ready_d;
  logic               overflow_q, overflow_d;
  logic               err_sof_q, err_sof_d;
  logic [CNT_W-1:0]   line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0]   last_len_q, last_len_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   line_base, line_inc;
  logic [ENTRY_W-1:0] head;
  logic               full, rd_en, wr_en, drop;
  logic               sof_hit, sof_err;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign m_tvalid = (count_q != '0);
  assign rd_en    = m_tvalid && m_tready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en    = in_tvalid && (!full || rd_en);
  assign drop     = in_tvalid && full && !rd_en;

  // Fields are forced to zero while empty so stale storage never shows after reset.
  assign head    = m_tvalid ? mem_q[rd_ptr_q] : '0;
  assign m_tdata = head[ENTRY_W-1 -: DATA_W];
  assign m_tuser = head[USER_W:1];
  assign m_tlast = head[0];

  assign in_ready      = in_ready_q;
  assign overflow      = overflow_q;
  assign err_sof       = err_sof_q;
  assign last_line_len = last_len_q;
  assign frame_cnt     = frame_cnt_q;

  // NOTE: storage has no reset; emptiness is tracked by count_q alone, so the
  // array can map onto plain RAM/flops without a reset network.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {in_tdata, in_tuser, in_tlast};
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    free_d     = (AW+1)'(DEPTH) - count_d;
    in_ready_d = (free_d > (AW+1)'(AF_MARGIN));
  end

  assign sof_hit   = rd_en && m_tuser[0];
  assign sof_err   = sof_hit && (line_cnt_q != '0);
  assign line_base = sof_err ? '0 : line_cnt_q;
  assign line_inc  = line_base + CNT_W'(1);

  always_comb begin
    line_cnt_d  = line_cnt_q;
    last_len_d  = last_len_q;
    frame_cnt_d = frame_cnt_q;
    if (rd_en) begin
      if (m_tlast) begin
        last_len_d = line_inc;
        line_cnt_d = '0;
      end else begin
        line_cnt_d = line_inc;
      end
    end
    if (sof_hit) frame_cnt_d = frame_cnt_q + CNT_W'(1);
    // A new event outranks a coincident clear.
    overflow_d = drop    || (overflow_q && !clr_status);
    err_sof_d  = sof_err || (err_sof_q  && !clr_status);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      overflow_q  <= 1'b0;
      err_sof_q   <= 1'b0;
      line_cnt_q  <= '0;
      last_len_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      overflow_q  <= overflow_d;
      err_sof_q   <= err_sof_d;
      line_cnt_q  <= line_cnt_d;
      last_len_q  <= last_len_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_video_stream_out_buffer.sv
// Directed bench for video_stream_out_buffer: ordering, throttle, overflow,
// stall stability, SOF framing errors and asynchronous reset flush.
module tb_video_stream_out_buffer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [23:0] in_tdata;
  logic [7:0]  in_tuser;
  logic        in_tvalid;
  logic        in_tlast;
  logic        in_ready;
  logic [23:0] m_tdata;
  logic [7:0]  m_tuser;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic        clr_status;
  logic        overflow;
  logic        err_sof;
  logic [15:0] last_line_len;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  video_stream_out_buffer dut (
    .clk(clk), .resetn(resetn),
    .in_tdata(in_tdata), .in_tuser(in_tuser), .in_tvalid(in_tvalid),
    .in_tlast(in_tlast), .in_ready(in_ready),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .clr_status(clr_status), .overflow(overflow), .err_sof(err_sof),
    .last_line_len(last_line_len), .frame_cnt(frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_beat(input logic [23:0] d, input logic [7:0] u, input logic l);
    in_tvalid = 1'b1;
    in_tdata  = d;
    in_tuser  = u;
    in_tlast  = l;
  endtask

  task automatic idle_in();
    in_tvalid = 1'b0;
    in_tdata  = '0;
    in_tuser  = '0;
    in_tlast  = 1'b0;
  endtask

  initial begin
    resetn     = 1'b0;
    m_tready   = 1'b1;
    clr_status = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_overflow", overflow, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    resetn = 1'b1;
    @(negedge clk);

    // 8-beat line, SOF on beat 1, tlast on beat 8, sink always ready
    for (int i = 1; i <= 8; i++) begin
      set_beat(24'(i), (i == 1) ? 8'h01 : 8'h00, i == 8);
      @(negedge clk);
      check("t1_tvalid", m_tvalid, 1);
      check("t1_tdata", m_tdata, 32'(i));
      if (i == 1) check("t1_sof", m_tuser, 8'h01);
    end
    idle_in();
    @(negedge clk);
    check("t1_empty", m_tvalid, 0);
    check("t1_line_len", last_line_len, 8);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_overflow", overflow, 0);
    check("t1_err_sof", err_sof, 0);

    // Fill to DEPTH with the sink stalled
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_beat(24'h100 + 24'(i), 8'h00, 1'b0);
      @(negedge clk);
      if (i == 10) check("t2_ready_11", in_ready, 1);
      if (i == 11) check("t2_ready_12", in_ready, 0);
    end
    check("t2_overflow_full", overflow, 0);
    set_beat(24'h1FF, 8'h00, 1'b0);
    @(negedge clk);
    idle_in();
    check("t2_overflow", overflow, 1);
    check("t2_head", m_tdata, 32'h100);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    check("t2_clr", overflow, 0);

    // Full FIFO: simultaneous write and read
    set_beat(24'h200, 8'h00, 1'b1);
    m_tready = 1'b1;
    @(negedge clk);
    idle_in();
    check("t3_overflow", overflow, 0);
    check("t3_in_ready", in_ready, 0);
    check("t3_head", m_tdata, 32'h101);
    for (int i = 2; i <= 16; i++) begin
      @(negedge clk);
      check("t3_drain", m_tdata, (i <= 15) ? 32'h100 + 32'(i) : 32'h200);
    end
    @(negedge clk);
    check("t3_empty", m_tvalid, 0);
    check("t3_line_len", last_line_len, 17);
    check("t3_in_ready_back", in_ready, 1);

    // Stall with data held
    m_tready = 1'b0;
    set_beat(24'h333, 8'hA0, 1'b0);
    @(negedge clk);
    set_beat(24'h444, 8'h00, 1'b1);
    @(negedge clk);
    idle_in();
    for (int k = 0; k < 3; k++) begin
      check("t4_tvalid", m_tvalid, 1);
      check("t4_tdata", m_tdata, 32'h333);
      check("t4_tuser", m_tuser, 8'hA0);
      check("t4_tlast", m_tlast, 0);
      @(negedge clk);
    end
    m_tready = 1'b1;
    check("t4_hold_end", m_tdata, 32'h333);
    @(negedge clk);
    check("t4_second", m_tdata, 32'h444);
    check("t4_second_last", m_tlast, 1);
    @(negedge clk);
    check("t4_line_len", last_line_len, 2);

    // SOF mid-line
    for (int i = 1; i <= 5; i++) begin
      set_beat(24'h500 + 24'(i), (i == 3) ? 8'h01 : 8'h00, i == 5);
      @(negedge clk);
    end
    idle_in();
    @(negedge clk);
    check("t5_err_sof", err_sof, 1);
    check("t5_frame_cnt", frame_cnt, 2);
    check("t5_line_len", last_line_len, 3);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    check("t5_clr", err_sof, 0);
    check("t5_frame_keep", frame_cnt, 2);

    // Partial line read, then 6 beats buffered, then reset
    for (int i = 0; i < 2; i++) begin
      set_beat(24'h6F0 + 24'(i), 8'h00, 1'b0);
      @(negedge clk);
    end
    idle_in();
    @(negedge clk);
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_beat(24'h600 + 24'(i), 8'h00, 1'b0);
      @(negedge clk);
    end
    idle_in();
    check("t6_buffered", m_tvalid, 1);
    check("t6_head", m_tdata, 32'h600);
    #2 resetn = 1'b0;
    #1;
    check("t6_async_tvalid", m_tvalid, 0);
    check("t6_async_tdata", m_tdata, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    m_tready = 1'b1;
    @(negedge clk);
    check("t6_post_tvalid", m_tvalid, 0);
    check("t6_post_in_ready", in_ready, 1);
    check("t6_post_frame", frame_cnt, 0);
    check("t6_post_line_len", last_line_len, 0);
    for (int i = 1; i <= 3; i++) begin
      set_beat(24'h700 + 24'(i), 8'h00, i == 3);
      @(negedge clk);
      check("t6_new_data", m_tdata, 32'h700 + 32'(i));
    end
    idle_in();
    @(negedge clk);
    check("t6_new_line_len", last_line_len, 3);
    check("t6_new_empty", m_tvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
